// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the character-LCD write-bus arbiter.
// The state encoding, requester indices and LCD command bytes live here so the bench can use them too.
package lcd_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ENABLE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_EXEC   = 3'd4
   } lcd_state_t;

   localparam int CNT_W = 17;

   localparam logic [1:0] REQ_ALARM = 2'd0;
   localparam logic [1:0] REQ_MENU  = 2'd1;
   localparam logic [1:0] REQ_CLOCK = 2'd2;

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;
   localparam logic [7:0] CMD_LINE1 = 8'h80;
   localparam logic [7:0] CMD_LINE2 = 8'hC0;

   // Clear (0x01) and home (0x02/0x03) need the long execution wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return (rs == 1'b0) && (data[7:2] == 6'd0) && (data != 8'd0);
   endfunction

   function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
      return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
   endfunction

endpackage

// File: rtl/lcd_prio_select.sv
// Lock-masked fixed-priority selector: while the owner holds its lock only the
// owner's request is eligible; otherwise the lowest-index request wins.
module lcd_prio_select
   import lcd_bus_pkg::*;
(
   input  logic [2:0] req,
   input  logic [2:0] lock,
   input  logic [1:0] owner,
   input  logic       owner_valid,
   output logic [2:0] winner,
   output logic       any,
   output logic       lock_held
);

   logic [2:0] owner_mask;
   logic [2:0] eligible;

   always_comb begin
      owner_mask = 3'b001 << owner;
      lock_held  = owner_valid && ((lock & owner_mask) != 3'b000);
      eligible   = lock_held ? (req & owner_mask) : req;
      winner     = 3'b000;
      if (eligible[REQ_ALARM])
         winner[REQ_ALARM] = 1'b1;
      else if (eligible[REQ_MENU])
         winner[REQ_MENU] = 1'b1;
      else if (eligible[REQ_CLOCK])
         winner[REQ_CLOCK] = 1'b1;
      any = (eligible != 3'b000);
   end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Owner of the HD44780-style write bus: arbitrates three requesters and walks each
// byte through setup / enable / hold / execution wait before acknowledging it.
module lcd_bus_arbiter
   import lcd_bus_pkg::*;
#(
   parameter int T_SETUP     = 2,
   parameter int T_EN        = 12,
   parameter int T_HOLD      = 2,
   parameter int T_EXEC      = 2000,
   parameter int T_EXEC_LONG = 76000
) (
   input  logic        CLK,
   input  logic        RESETN,
   input  logic [2:0]  REQ,
   input  logic [2:0]  LOCK,
   input  logic [2:0]  RS_IN,
   input  logic [23:0] DATA_IN,
   output logic [2:0]  GNT,
   output logic [2:0]  ACK,
   output logic        BUSY,
   output logic        LCD_E,
   output logic        LCD_RS,
   output logic        LCD_RW,
   output logic [7:0]  LCD_DATA
);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(T_EXEC - 1);
   localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(T_EXEC_LONG - 1);

   lcd_state_t       state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] exec_last;
   logic [2:0]       gnt_q;
   logic             rs_q;
   logic [7:0]       data_q;
   logic [1:0]       owner_q;
   logic             owner_valid_q;
   logic [2:0]       winner;
   logic             any;
   logic             lock_held;
   logic [1:0]       win_idx;

   lcd_prio_select u_prio (
      .req         (REQ),
      .lock        (LOCK),
      .owner       (owner_q),
      .owner_valid (owner_valid_q),
      .winner      (winner),
      .any         (any),
      .lock_held   (lock_held)
   );

   assign win_idx   = onehot_idx(winner);
   assign exec_last = is_long_cmd(rs_q, data_q) ? LONG_LAST : EXEC_LAST;

   // State register, cycle counter, transfer latches and lock ownership.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         gnt_q         <= 3'b000;
         rs_q          <= 1'b0;
         data_q        <= 8'h00;
         owner_q       <= 2'd0;
         owner_valid_q <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= (state_next != state) ? '0 : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         if (state == ST_IDLE) begin
            if (any) begin
               gnt_q  <= winner;
               rs_q   <= RS_IN[win_idx];
               data_q <= DATA_IN[{win_idx, 3'b000} +: 8];
               if ((LOCK & winner) != 3'b000) begin
                  owner_q       <= win_idx;
                  owner_valid_q <= 1'b1;
               end else begin
                  owner_valid_q <= 1'b0;
               end
            end else if (owner_valid_q && !lock_held) begin
               owner_valid_q <= 1'b0;
            end
         end else if (state_next == ST_IDLE) begin
            gnt_q <= 3'b000;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (any)               state_next = ST_SETUP;
         ST_SETUP:  if (cnt == SETUP_LAST) state_next = ST_ENABLE;
         ST_ENABLE: if (cnt == EN_LAST)    state_next = ST_HOLD;
         ST_HOLD:   if (cnt == HOLD_LAST)  state_next = ST_EXEC;
         ST_EXEC:   if (cnt == exec_last)  state_next = ST_IDLE;
         default:                          state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      GNT      = gnt_q;
      ACK      = 3'b000;
      BUSY     = (state != ST_IDLE);
      LCD_E    = (state == ST_ENABLE);
      LCD_RS   = rs_q;
      LCD_DATA = data_q;
      LCD_RW   = 1'b0;
      if ((state == ST_EXEC) && (cnt == exec_last))
         ACK = gnt_q;
   end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: expected transfers are queued in service order
// and each granted transfer is measured against the head of that queue.
module tb_lcd_bus_arbiter;
   import lcd_bus_pkg::*;

   localparam int T_SETUP     = 2;
   localparam int T_EN        = 12;
   localparam int T_HOLD      = 2;
   localparam int T_EXEC      = 20;
   localparam int T_EXEC_LONG = 90;
   localparam int W           = 11;

   logic        CLK = 1'b0;
   logic        RESETN;
   logic [2:0]  REQ, LOCK, RS_IN;
   logic [23:0] DATA_IN;
   logic [2:0]  GNT, ACK;
   logic        BUSY, LCD_E, LCD_RS, LCD_RW;
   logic [7:0]  LCD_DATA;

   logic [W-1:0] exp_q[$];
   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int gap;

   lcd_bus_arbiter #(
      .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD),
      .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG)
   ) dut (
      .CLK(CLK), .RESETN(RESETN), .REQ(REQ), .LOCK(LOCK), .RS_IN(RS_IN),
      .DATA_IN(DATA_IN), .GNT(GNT), .ACK(ACK), .BUSY(BUSY), .LCD_E(LCD_E),
      .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
   );

   // clock / cycle counter
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic set_req(input int idx, input logic rs, input logic [7:0] data);
      REQ[idx]          = 1'b1;
      RS_IN[idx]        = rs;
      DATA_IN[8*idx+:8] = data;
   endtask

   task automatic push_exp(input logic [1:0] idx, input logic rs, input logic [7:0] data);
      exp_q.push_back({idx, rs, data});
   endtask

   // Waits for the next grant, follows it to its ACK and compares against the queue head.
   // Returns at the sample where ACK is high, so the caller can update inputs on that edge.
   task automatic serve_one(input bit corrupt, output int idle_gap);
      logic [W-1:0] e;
      logic [1:0]   idx;
      logic         rs;
      logic [7:0]   d;
      logic [2:0]   ack_v;
      int total, t0, e_first, e_cnt, bad, stray, ack_at;
      bit got, acked;
      idle_gap = 0;
      check("queue_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      {idx, rs, d} = e;
      total = T_SETUP + T_EN + T_HOLD +
              ((!rs && (d == CMD_CLEAR || d == CMD_HOME || d == 8'h03)) ? T_EXEC_LONG : T_EXEC);
      got = 0; stray = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge CLK);
         if (GNT !== 3'b000) got = 1;
         else begin
            idle_gap++;
            if (ACK !== 3'b000) stray++;
         end
      end
      check("grant_seen", got, 1);
      check("gnt_owner", GNT, 3'b001 << idx);
      check("no_ack_while_idle", stray, 0);
      t0 = cyc; e_first = -1; e_cnt = 0; bad = 0; acked = 0; ack_at = -1; ack_v = 3'b000;
      for (int i = 0; i < total + 10 && !acked; i++) begin
         if (i > 0) @(negedge CLK);
         if (LCD_RS !== rs || LCD_DATA !== d) bad++;
         if (GNT !== (3'b001 << idx) || BUSY !== 1'b1 || LCD_RW !== 1'b0) bad++;
         if (LCD_E === 1'b1) begin
            if (e_first < 0) e_first = cyc - t0;
            e_cnt++;
         end
         if (ACK !== 3'b000) begin
            acked = 1; ack_at = cyc - t0; ack_v = ACK;
         end
         if (corrupt && i == 0) begin
            DATA_IN[8*idx+:8] = 8'hFF;
            REQ[idx]          = 1'b0;
         end
      end
      check("ack_seen", acked, 1);
      check("ack_value", ack_v, 3'b001 << idx);
      check("ack_cycle", ack_at, total - 1);
      check("e_rise_cycle", e_first, T_SETUP);
      check("e_high_cycles", e_cnt, T_EN);
      check("bus_stable", bad, 0);
   endtask

   initial begin
      int seen;
      RESETN = 1'b0; REQ = '0; LOCK = '0; RS_IN = '0; DATA_IN = '0;
      repeat (3) @(negedge CLK);
      check("rst_gnt", GNT, 0);
      check("rst_ack", ACK, 0);
      check("rst_busy", BUSY, 0);
      check("rst_e", LCD_E, 0);
      check("rst_rs", LCD_RS, 0);
      check("rst_data", LCD_DATA, 0);
      check("rst_rw", LCD_RW, 0);
      RESETN = 1'b1;
      @(negedge CLK);

      // single data write from the clock renderer
      set_req(2, 1'b1, 8'h41); push_exp(2, 1'b1, 8'h41);
      serve_one(0, gap);
      REQ[2] = 1'b0;

      // clear command (long wait) then a line-address command on the next IDLE
      set_req(1, 1'b0, CMD_CLEAR); push_exp(1, 1'b0, CMD_CLEAR);
      serve_one(0, gap);
      set_req(1, 1'b0, CMD_LINE1); push_exp(1, 1'b0, CMD_LINE1);
      serve_one(0, gap);
      check("clear_line1_gap", gap, 1);
      REQ[1] = 1'b0;

      // contention: all three at once
      repeat (4) @(negedge CLK);
      set_req(0, 1'b1, 8'h10); set_req(1, 1'b1, 8'h20); set_req(2, 1'b1, 8'h30);
      push_exp(0, 1'b1, 8'h10); push_exp(1, 1'b1, 8'h20); push_exp(2, 1'b1, 8'h30);
      serve_one(0, gap);
      REQ[0] = 1'b0;
      serve_one(0, gap);
      check("contend_gap_1", gap, 1);
      REQ[1] = 1'b0;
      serve_one(0, gap);
      check("contend_gap_2", gap, 1);
      REQ[2] = 1'b0;

      // lock: requester 2 streams four bytes while requester 0 waits
      repeat (3) @(negedge CLK);
      LOCK[2] = 1'b1;
      set_req(2, 1'b1, 8'hA0); push_exp(2, 1'b1, 8'hA0);
      serve_one(0, gap);
      set_req(0, 1'b1, 8'h5A);
      set_req(2, 1'b1, 8'hA1); push_exp(2, 1'b1, 8'hA1);
      serve_one(0, gap);
      check("lock_b2_gap", gap, 1);
      set_req(2, 1'b1, 8'hA2); push_exp(2, 1'b1, 8'hA2);
      serve_one(0, gap);
      set_req(2, 1'b1, 8'hA3); push_exp(2, 1'b1, 8'hA3);
      serve_one(0, gap);
      REQ[2] = 1'b0; LOCK[2] = 1'b0;
      push_exp(0, 1'b1, 8'h5A);
      serve_one(0, gap);
      check("lock_release_gap", gap, 1);
      REQ[0] = 1'b0;

      // DATA_IN changed and REQ dropped during SETUP: latched byte goes out, ACK still comes
      repeat (3) @(negedge CLK);
      set_req(2, 1'b1, 8'h41); push_exp(2, 1'b1, 8'h41);
      serve_one(1, gap);
      seen = 0;
      repeat (5) begin
         @(negedge CLK);
         if (GNT !== 3'b000) seen++;
      end
      check("no_regrant_after_drop", seen, 0);

      // reset while E is high
      set_req(1, 1'b1, 8'h33);
      seen = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
         @(negedge CLK);
         if (LCD_E === 1'b1) seen = 1;
      end
      check("e_seen_before_reset", seen, 1);
      #2 RESETN = 1'b0;
      #1;
      check("midrst_e", LCD_E, 0);
      check("midrst_gnt", GNT, 0);
      check("midrst_busy", BUSY, 0);
      check("midrst_ack", ACK, 0);
      @(negedge CLK);
      RESETN = 1'b1;
      push_exp(1, 1'b1, 8'h33);
      serve_one(0, gap);
      REQ[1] = 1'b0;

      repeat (3) @(negedge CLK);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
